// File: rtl/ysyx_23060096_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_rf_wb_arbiter
//
// Purpose:
//   Register-file write-port controller for an RV32 core. The EXU (req0) and
//   the LSU (req1) share a single RF write port. A round-robin arbiter with a
//   one-bit priority FSM picks one requester per cycle. The chosen write is
//   registered and presented to the RF as w_en/waddr/wdata one cycle later.
//   A busy scoreboard tracks destinations that have been issued but not yet
//   written back, so the IDU can stall on RAW/WAW hazards.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   hold                           freezes arbitration (no ready asserted)
//   req0_valid/ready/addr/data     EXU writeback handshake
//   req1_valid/ready/addr/data     LSU writeback handshake
//   w_en, waddr, wdata             registered RF write port
//   iss_valid, iss_ready, iss_rd   IDU issue handshake for destination rd
//   ra, rb, busy_a, busy_b         combinational operand-busy lookups
// ---------------------------------------------------------------------------
module ysyx_23060096_rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,

  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,

  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic [ADDR_WIDTH-1:0] iss_rd,

  input  logic [ADDR_WIDTH-1:0] ra,
  input  logic [ADDR_WIDTH-1:0] rb,
  output logic                  busy_a,
  output logic                  busy_b
);

  localparam int NREG = 1 << ADDR_WIDTH;

  typedef enum logic {
    P0 = 1'b0,  // req0 favoured on a tie
    P1 = 1'b1   // req1 favoured on a tie
  } prio_e;

  prio_e                 prio_q, prio_d;
  logic                  w_en_q, w_en_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]       busy_q, busy_d;

  logic grant0, grant1;
  logic iss_fire;

  // Readies are also suppressed during reset so nothing is handshaken while
  // the write path is being cleared.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && !hold) begin
      if (req0_valid && req1_valid) begin
        grant0 = (prio_q == P0);
        grant1 = (prio_q == P1);
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Priority FSM: the requester just served loses priority on the next tie.
  always_comb begin
    prio_d = prio_q;
    if (grant0) begin
      prio_d = P1;
    end else if (grant1) begin
      prio_d = P0;
    end
  end

  // Write path: a grant to x0 is accepted but never produces a write enable.
  always_comb begin
    w_en_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (grant0) begin
      w_en_d  = (req0_addr != '0);
      waddr_d = req0_addr;
      wdata_d = req0_data;
    end else if (grant1) begin
      w_en_d  = (req1_addr != '0);
      waddr_d = req1_addr;
      wdata_d = req1_data;
    end
  end

  // Scoreboard: clear on RF commit, then set on issue, so a same-edge
  // set/clear of one index leaves the bit set.
  assign iss_ready = !busy_q[iss_rd] || (iss_rd == '0);
  assign iss_fire  = iss_valid && iss_ready && (iss_rd != '0);

  always_comb begin
    busy_d = busy_q;
    if (w_en_q) begin
      busy_d[waddr_q] = 1'b0;
    end
    if (iss_fire) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q  <= P0;
      w_en_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      prio_q  <= prio_d;
      w_en_q  <= w_en_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign w_en   = w_en_q;
  assign waddr  = waddr_q;
  assign wdata  = wdata_q;
  assign busy_a = busy_q[ra] && (ra != '0);
  assign busy_b = busy_q[rb] && (rb != '0);

endmodule

// File: tb/tb_ysyx_23060096_rf_wb_arbiter.sv
module tb_ysyx_23060096_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hold = 1'b0;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [4:0]  req0_addr = '0;
  logic [31:0] req0_data = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [4:0]  req1_addr = '0;
  logic [31:0] req1_data = '0;
  logic        w_en;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        iss_valid = 1'b0;
  logic        iss_ready;
  logic [4:0]  iss_rd = '0;
  logic [4:0]  ra = '0;
  logic [4:0]  rb = '0;
  logic        busy_a;
  logic        busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_23060096_rf_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .w_en(w_en), .waddr(waddr), .wdata(wdata),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
    .ra(ra), .rb(rb), .busy_a(busy_a), .busy_b(busy_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hAAAA0001;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'hBBBB0002;
    ra = 5'd5; rb = 5'd6;
    tick();
    tick();
    n_tests++; if (w_en !== 1'b0) begin n_fail++; $display("FAIL reset_w_en got %b want 0", w_en); end
    n_tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b%b want 00", req0_ready, req1_ready); end
    n_tests++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b%b want 00", busy_a, busy_b); end
    n_tests++; if (waddr !== 5'd0 || wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wport got %0h/%0h want 0/0", waddr, wdata); end
    rst = 1'b0;
    #1;
    n_tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_first_grant got %b%b want 10", req0_ready, req1_ready); end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        n_fail++; $display("FAIL rr_grant%0d got %b%b want %b%b", i, req0_ready, req1_ready, (i % 2 == 0), (i % 2 == 1));
      end
      tick();
      n_tests++;
      if (w_en !== 1'b1 || waddr !== ((i % 2 == 0) ? 5'd5 : 5'd6) ||
          wdata !== ((i % 2 == 0) ? 32'hAAAA0001 : 32'hBBBB0002)) begin
        n_fail++; $display("FAIL rr_write%0d got %b/%0d/%h", i, w_en, waddr, wdata);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    n_tests++; if (w_en !== 1'b0 || waddr !== 5'd6 || wdata !== 32'hBBBB0002) begin n_fail++; $display("FAIL rr_idle got %b/%0d/%h want 0/6/bbbb0002", w_en, waddr, wdata); end
  endtask

  task automatic test_single();
    req1_valid = 1'b1; req1_addr = 5'd9;
    for (int i = 0; i < 3; i++) begin
      req1_data = 32'h100 + i;
      #1;
      n_tests++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready%0d got %b%b want 01", i, req0_ready, req1_ready); end
      tick();
      n_tests++; if (w_en !== 1'b1 || waddr !== 5'd9 || wdata !== 32'h100 + i) begin n_fail++; $display("FAIL single_write%0d got %b/%0d/%h want 1/9/%h", i, w_en, waddr, wdata, 32'h100 + i); end
    end
    req1_valid = 1'b0;
    tick();
    n_tests++; if (w_en !== 1'b0) begin n_fail++; $display("FAIL single_end got %b want 0", w_en); end
  endtask

  task automatic test_x0();
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hFFFFFFFF;
    #1;
    n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready got %b want 1", req0_ready); end
    tick();
    n_tests++; if (w_en !== 1'b0) begin n_fail++; $display("FAIL x0_w_en got %b want 0", w_en); end
    req0_valid = 1'b0;
    tick();
  endtask

  // prio is P1 here (last grant went to req0)
  task automatic test_scoreboard();
    ra = 5'd7; rb = 5'd0;
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    n_tests++; if (iss_ready !== 1'b1 || busy_a !== 1'b0) begin n_fail++; $display("FAIL sb_pre got ready=%b busy=%b want 1/0", iss_ready, busy_a); end
    tick();
    n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL sb_set got %b want 1", busy_a); end
    n_tests++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL sb_waw_stall got %b want 0", iss_ready); end
    n_tests++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL sb_x0 got %b want 0", busy_b); end
    iss_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h77;
    #1;
    n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL sb_wb_ready got %b want 1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    n_tests++; if (w_en !== 1'b1 || waddr !== 5'd7 || busy_a !== 1'b1) begin n_fail++; $display("FAIL sb_wb_cycle got %b/%0d busy=%b want 1/7/1", w_en, waddr, busy_a); end
    tick();
    n_tests++; if (w_en !== 1'b0 || busy_a !== 1'b0 || iss_ready !== 1'b1) begin n_fail++; $display("FAIL sb_clear got w_en=%b busy=%b iss_ready=%b want 0/0/1", w_en, busy_a, iss_ready); end
  endtask

  // prio is P0 here (last grant went to req1)
  task automatic test_collision_hold();
    ra = 5'd3;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
    tick();
    req0_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd3;
    #1;
    n_tests++; if (w_en !== 1'b1 || waddr !== 5'd3 || iss_ready !== 1'b1) begin n_fail++; $display("FAIL coll_setup got %b/%0d iss_ready=%b want 1/3/1", w_en, waddr, iss_ready); end
    tick();
    iss_valid = 1'b0;
    n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL coll_set_wins got %b want 1", busy_a); end
    hold = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready%0d got %b%b want 00", i, req0_ready, req1_ready); end
      tick();
      n_tests++; if (w_en !== 1'b0) begin n_fail++; $display("FAIL hold_w_en%0d got %b want 0", i, w_en); end
    end
    hold = 1'b0;
    #1;
    n_tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin n_fail++; $display("FAIL hold_prio_kept got %b%b want 01", req0_ready, req1_ready); end
    tick();
    n_tests++; if (w_en !== 1'b1 || waddr !== 5'd2 || wdata !== 32'h22) begin n_fail++; $display("FAIL hold_release got %b/%0d/%h want 1/2/22", w_en, waddr, wdata); end
  endtask

  // Async reset in the middle of a pending write
  task automatic test_reset_mid();
    req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hCAFE;
    req1_valid = 1'b0;
    tick();
    n_tests++; if (w_en !== 1'b1 || waddr !== 5'd10) begin n_fail++; $display("FAIL mid_pre got %b/%0d want 1/10", w_en, waddr); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (w_en !== 1'b0 || busy_a !== 1'b0 || wdata !== 32'd0) begin n_fail++; $display("FAIL mid_reset got w_en=%b busy=%b wdata=%h want 0/0/0", w_en, busy_a, wdata); end
    req0_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_x0();
    test_scoreboard();
    test_collision_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
